// File: rtl/pc_sequencer_if.sv
// Bundle of the sequencer's decode, LUT and fetch signals.
// The slave modport is the sequencer itself. The master modport is its
// environment: decode, the branch-target LUT and instruction memory.
interface pc_sequencer_if #(
  parameter int D = 10,
  parameter int A = 8
);
  logic         start;
  logic [A-1:0] start_idx;
  logic         br_taken;
  logic [A-1:0] br_idx;
  logic         halt;
  logic         stall;
  logic [A-1:0] lut_addr;
  logic         lut_branch;
  logic [D-1:0] lut_target;
  logic [D-1:0] pc;
  logic         fetch_valid;
  logic         done;
  logic         fault;
  logic [15:0]  cycle_cnt;

  modport master (
    output start, start_idx, br_taken, br_idx, halt, stall, lut_target,
    input  lut_addr, lut_branch, pc, fetch_valid, done, fault, cycle_cnt
  );

  modport slave (
    input  start, start_idx, br_taken, br_idx, halt, stall, lut_target,
    output lut_addr, lut_branch, pc, fetch_valid, done, fault, cycle_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer.
// It reads branch and launch targets from an external combinational LUT.
// It then advances, holds or redirects the PC, and flags out-of-range PCs
// with a sticky fault.
// Optional feature: define PC_SEQ_BR_DELAY_EN to register taken-branch
// targets and spend one BRWAIT bubble before the redirect. Without it,
// branches redirect on the same edge.
module pc_sequencer #(
  parameter int D        = 10,
  parameter int A        = 8,
  parameter int PROG_LEN = 400
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus_if
);

  localparam logic [D:0] PROG_LIM = (D+1)'(PROG_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
`ifdef PC_SEQ_BR_DELAY_EN
    S_BRWAIT,
`endif
    S_DONE,
    S_FAULT
  } state_e;

  state_e       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [D-1:0] pc_inc;
  logic [15:0]  cnt_sat;
  logic [A-1:0] lut_addr;
  logic         lut_branch;
`ifdef PC_SEQ_BR_DELAY_EN
  logic [D-1:0] tgt_q, tgt_d;
`endif

  // Legal fetch addresses are strictly below PROG_LEN.
  function automatic logic in_range(input logic [D-1:0] v);
    return {1'b0, v} < PROG_LIM;
  endfunction

  assign pc_inc  = pc_q + D'(1);  // wraps modulo 2^D
  assign cnt_sat = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Next-state, PC/counter update and LUT drive.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    lut_addr   = '0;
    lut_branch = 1'b0;
`ifdef PC_SEQ_BR_DELAY_EN
    tgt_d      = tgt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus_if.start) begin
          lut_addr   = bus_if.start_idx;
          lut_branch = 1'b1;
          if (in_range(bus_if.lut_target)) begin
            pc_d    = bus_if.lut_target;
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_RUN: begin
        if (bus_if.br_taken) begin
          lut_addr   = bus_if.br_idx;
          lut_branch = 1'b1;
        end
        cnt_d = cnt_sat;
        if (bus_if.halt) begin
          state_d = S_DONE;
        end else if (!bus_if.stall) begin
          // A stalled cycle drops any branch; decode re-presents it later.
          if (bus_if.br_taken) begin
            if (!in_range(bus_if.lut_target)) begin
              state_d = S_FAULT;
            end else begin
`ifdef PC_SEQ_BR_DELAY_EN
              tgt_d   = bus_if.lut_target;
              state_d = S_BRWAIT;
`else
              pc_d    = bus_if.lut_target;
`endif
            end
          end else if (!in_range(pc_inc)) begin
            state_d = S_FAULT;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
`ifdef PC_SEQ_BR_DELAY_EN
      S_BRWAIT: begin
        cnt_d = cnt_sat;
        if (!bus_if.stall) begin
          pc_d    = tgt_q;
          state_d = S_RUN;
        end
      end
`endif
      S_FAULT: begin
        // Frozen until reset.
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, PC and cycle-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
`ifdef PC_SEQ_BR_DELAY_EN
      tgt_q   <= '0;
`endif
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
`ifdef PC_SEQ_BR_DELAY_EN
      tgt_q   <= tgt_d;
`endif
    end
  end

  assign bus_if.lut_addr    = lut_addr;
  assign bus_if.lut_branch  = lut_branch;
  assign bus_if.pc          = pc_q;
  assign bus_if.fetch_valid = (state_q == S_RUN);
  assign bus_if.done        = (state_q == S_DONE);
  assign bus_if.fault       = (state_q == S_FAULT);
  assign bus_if.cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer.
// It runs the directed scenarios first, then a randomized run.
// A cycle-level behavioural model and a LUT array predict every output.
module tb_pc_sequencer;
  localparam int D        = 10;
  localparam int A        = 8;
  localparam int PROG_LEN = 400;
`ifdef PC_SEQ_BR_DELAY_EN
  localparam bit BR_DELAY = 1'b1;
`else
  localparam bit BR_DELAY = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic [D-1:0] lut [2**A];

  pc_sequencer_if #(.D(D), .A(A)) bus ();

  pc_sequencer #(.D(D), .A(A), .PROG_LEN(PROG_LEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  assign bus.lut_target = lut[bus.lut_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: a few mode flags plus PC, counter and pending target.
  bit m_run, m_wait, m_done, m_fault;
  int m_pc, m_cnt, m_tgt;

  task automatic model_reset();
    m_run = 0; m_wait = 0; m_done = 0; m_fault = 0;
    m_pc = 0; m_cnt = 0; m_tgt = 0;
  endtask

  task automatic model_step();
    int nxt;
    if (m_fault) return;
    if (!m_run && !m_wait) begin
      if (bus.start) begin
        nxt = lut[bus.start_idx];
        if (nxt >= PROG_LEN) begin
          m_fault = 1; m_done = 0;
        end else begin
          m_pc = nxt; m_cnt = 0; m_done = 0; m_run = 1;
        end
      end
      return;
    end
    if (m_cnt < 65535) m_cnt++;
    if (m_wait) begin
      if (!bus.stall) begin
        m_pc = m_tgt; m_wait = 0; m_run = 1;
      end
      return;
    end
    if (bus.halt) begin
      m_run = 0; m_done = 1;
    end else if (!bus.stall) begin
      nxt = bus.br_taken ? int'(lut[bus.br_idx]) : (m_pc + 1) % (2**D);
      if (nxt >= PROG_LEN) begin
        m_fault = 1; m_run = 0;
      end else if (bus.br_taken && BR_DELAY) begin
        m_tgt = nxt; m_wait = 1; m_run = 0;
      end else begin
        m_pc = nxt;
      end
    end
  endtask

  task automatic check_lut();
    int ea;
    int eb;
    ea = 0; eb = 0;
    if (!m_fault) begin
      if (!m_run && !m_wait) begin
        if (bus.start) begin ea = bus.start_idx; eb = 1; end
      end else if (m_run && bus.br_taken) begin
        ea = bus.br_idx; eb = 1;
      end
    end
    check("lut_addr", bus.lut_addr, ea);
    check("lut_branch", bus.lut_branch, eb);
  endtask

  task automatic check_state();
    check("pc", bus.pc, m_pc);
    check("fetch_valid", bus.fetch_valid, m_run);
    check("done", bus.done, m_done);
    check("fault", bus.fault, m_fault);
    check("cycle_cnt", bus.cycle_cnt, m_cnt);
  endtask

  task automatic set_inputs(input bit s, input logic [A-1:0] si, input bit b,
                            input logic [A-1:0] bi, input bit h, input bit st);
    bus.start = s; bus.start_idx = si; bus.br_taken = b;
    bus.br_idx = bi; bus.halt = h; bus.stall = st;
  endtask

  // One clock: drive after the falling edge, check the LUT drive, let the
  // rising edge happen, then check registered outputs at the next falling edge.
  task automatic tick(input bit s, input logic [A-1:0] si, input bit b,
                      input logic [A-1:0] bi, input bit h, input bit st);
    set_inputs(s, si, b, bi, h, st);
    #1;
    check_lut();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_state();
  endtask

  task automatic idle_tick();
    tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic launch(input logic [A-1:0] idx);
    tick(1'b1, idx, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic halt_tick();
    tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset pulse between clock edges, checked before the next edge.
  task automatic do_reset();
    set_inputs(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2**A; i++)
      lut[i] = ($urandom_range(0, 19) == 0) ? D'($urandom_range(PROG_LEN, 2**D - 1))
                                            : D'($urandom_range(0, PROG_LEN - 1));
    lut[0] = D'(0);   lut[1] = D'(26);  lut[16] = D'(4);  lut[5] = D'(450);
    lut[3] = D'(57);  lut[6] = D'(10);  lut[7]  = D'(20); lut[8] = D'(30);
    lut[9] = D'(399);

    set_inputs(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pc", bus.pc, 0);
    check("rst_fetch_valid", bus.fetch_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_cycle_cnt", bus.cycle_cnt, 0);
    rst_n = 1'b1;

    // Launch from LUT entry 16 (target 4), then free-run three cycles.
    set_inputs(1'b1, A'(16), 1'b0, '0, 1'b0, 1'b0);
    #1;
    check("start_lut_addr", bus.lut_addr, 16);
    check("start_lut_branch", bus.lut_branch, 1);
    launch(A'(16));
    check("start_pc", bus.pc, 4);
    check("start_fetch_valid", bus.fetch_valid, 1);
    repeat (3) idle_tick();
    check("run_pc", bus.pc, 7);

    // Taken branch at PC=10 to LUT entry 1 (target 26).
    halt_tick();
    launch(A'(6));
    check("br_pre_pc", bus.pc, 10);
    tick(1'b0, '0, 1'b1, A'(1), 1'b0, 1'b0);
    check("br_pc", bus.pc, BR_DELAY ? 10 : 26);
    check("br_fetch_valid", bus.fetch_valid, BR_DELAY ? 0 : 1);
    if (BR_DELAY) idle_tick();
    check("br_target_pc", bus.pc, 26);
    check("br_cycle_cnt", bus.cycle_cnt, BR_DELAY ? 2 : 1);

    // Stall for three cycles at PC=20 with a branch presented: no redirect.
    halt_tick();
    launch(A'(7));
    repeat (3) tick(1'b0, '0, 1'b1, A'(1), 1'b0, 1'b1);
    check("stall_pc", bus.pc, 20);
    idle_tick();
    check("stall_release_pc", bus.pc, 21);

    // Halt and branch together at PC=30: halt wins; then relaunch at entry 0.
    halt_tick();
    launch(A'(8));
    tick(1'b0, '0, 1'b1, A'(1), 1'b1, 1'b0);
    check("halt_pc", bus.pc, 30);
    check("halt_done", bus.done, 1);
    check("halt_fetch_valid", bus.fetch_valid, 0);
    launch(A'(0));
    check("relaunch_pc", bus.pc, 0);
    check("relaunch_done", bus.done, 0);
    check("relaunch_fetch_valid", bus.fetch_valid, 1);

    // Asynchronous reset while running at PC=57.
    halt_tick();
    launch(A'(3));
    tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    check("pre_arst_pc", bus.pc, 57);
    set_inputs(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc", bus.pc, 0);
    check("arst_fetch_valid", bus.fetch_valid, 0);
    check("arst_done", bus.done, 0);
    check("arst_cycle_cnt", bus.cycle_cnt, 0);
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Fault: branch to LUT entry 5 whose target is 450.
    launch(A'(0));
    tick(1'b0, '0, 1'b1, A'(5), 1'b0, 1'b0);
    check("fault_br_fault", bus.fault, 1);
    check("fault_br_pc", bus.pc, 0);
    check("fault_br_fetch_valid", bus.fetch_valid, 0);
    launch(A'(16));
    check("fault_start_ignored_pc", bus.pc, 0);
    check("fault_start_ignored_fault", bus.fault, 1);
    do_reset();

    // Fault: increment past the last legal PC (399).
    launch(A'(9));
    check("last_pc", bus.pc, 399);
    idle_tick();
    check("fault_inc_fault", bus.fault, 1);
    check("fault_inc_pc", bus.pc, 399);
    do_reset();

    // Randomized run against the model, with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, m_fault ? 20 : 400) == 0) do_reset();
      tick($urandom_range(0, 3) == 0, A'($urandom_range(0, 2**A - 1)),
           $urandom_range(0, 3) == 0, A'($urandom_range(0, 2**A - 1)),
           $urandom_range(0, 40) == 0, $urandom_range(0, 4) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
